// File: rtl/pattern_detector3.sv
// Sliding-window detector for a programmable 3-byte pattern on an ack-qualified byte stream.
// The hit flag is registered and sticky until the consumer drops ack for one edge.
module pattern_detector3 #(
    parameter logic [7:0] BYTE0 = 8'h12,
    parameter logic [7:0] BYTE1 = 8'h34,
    parameter logic [7:0] BYTE2 = 8'h56
) (
    input  logic       clk,
    input  logic       reset_sync,
    input  logic [7:0] data,
    input  logic       ack,
    output logic       found_pattern
);

    typedef enum logic {
        SEARCH = 1'b0,
        FOUND  = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  h1_reg, h1_next;
    logic [7:0]  h0_reg, h0_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic        match;

    // Window is complete only when two older bytes are held and the incoming byte closes it.
    assign match = (cnt_reg == 2'd2) && (h1_reg == BYTE0) && (h0_reg == BYTE1) && (data == BYTE2);

    always_ff @(posedge clk) begin
        if (reset_sync) begin
            state_reg <= SEARCH;
            h1_reg    <= 8'h00;
            h0_reg    <= 8'h00;
            cnt_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            h1_reg    <= h1_next;
            h0_reg    <= h0_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        h1_next    = h1_reg;
        h0_next    = h0_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            SEARCH: begin
                if (ack) begin
                    if (match) begin
                        state_next = FOUND;
                        h1_next    = 8'h00;
                        h0_next    = 8'h00;
                        cnt_next   = 2'd0;
                    end else begin
                        h1_next  = h0_reg;
                        h0_next  = data;
                        cnt_next = (cnt_reg == 2'd2) ? 2'd2 : cnt_reg + 2'd1;
                    end
                end
            end
            FOUND: begin
                // ack low is the acknowledge; the byte on data at that edge is dropped.
                if (!ack) begin
                    state_next = SEARCH;
                    h1_next    = 8'h00;
                    h0_next    = 8'h00;
                    cnt_next   = 2'd0;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    assign found_pattern = (state_reg == FOUND);

endmodule

// File: tb/tb_pattern_detector3.sv
// Bench for pattern_detector3: a byte-queue reference model pushes the expected flag per edge,
// which is popped and compared one time unit after that edge.
module tb_pattern_detector3;

    localparam logic [7:0] P0 = 8'h12;
    localparam logic [7:0] P1 = 8'h34;
    localparam logic [7:0] P2 = 8'h56;

    logic       clk = 1'b0;
    logic       reset_sync = 1'b1;
    logic [7:0] data = 8'h00;
    logic       ack = 1'b0;
    logic       found_pattern;

    int n_checks = 0;
    int n_fail   = 0;

    logic       exp_q[$];
    logic [7:0] m_hist[$];
    logic       m_found = 1'b0;

    pattern_detector3 #(.BYTE0(P0), .BYTE1(P1), .BYTE2(P2)) dut (
        .clk          (clk),
        .reset_sync   (reset_sync),
        .data         (data),
        .ack          (ack),
        .found_pattern(found_pattern)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: found_pattern=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference: remembers up to the last three accepted bytes since the last clear.
    task automatic model_step(input logic rst, input logic a, input logic [7:0] d);
        if (rst) begin
            m_found = 1'b0;
            m_hist.delete();
        end else if (!m_found) begin
            if (a) begin
                m_hist.push_back(d);
                if (m_hist.size() > 3) void'(m_hist.pop_front());
                if (m_hist.size() == 3 && m_hist[0] == P0 && m_hist[1] == P1 && m_hist[2] == P2) begin
                    m_found = 1'b1;
                    m_hist.delete();
                end
            end
        end else if (!a) begin
            m_found = 1'b0;
            m_hist.delete();
        end
    endtask

    // One clock: drive inputs, push the model's prediction, then pop and compare after the edge.
    task automatic cyc(input string tag, input logic rst, input logic a, input logic [7:0] d);
        logic exp;
        @(negedge clk);
        reset_sync = rst;
        ack        = a;
        data       = d;
        model_step(rst, a, d);
        exp_q.push_back(m_found);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check_eq(tag, found_pattern, exp);
        $display("%-10s rst=%b ack=%b data=%02h -> found=%b (exp %b)", tag, rst, a, d, found_pattern, exp);
    endtask

    task automatic ackbyte(input string tag, input logic [7:0] d);
        cyc(tag, 1'b0, 1'b1, d);
    endtask

    initial begin
        cyc("reset", 1'b1, 1'b0, 8'h00);
        cyc("reset", 1'b1, 1'b1, 8'h56);
        check_eq("reset_val", found_pattern, 1'b0);

        // Basic hit, sticky while ack high
        ackbyte("basic", P0); ackbyte("basic", P1);
        check_eq("pre_hit", found_pattern, 1'b0);
        ackbyte("basic", P2);
        check_eq("hit_latency", found_pattern, 1'b1);
        ackbyte("sticky", 8'h00); ackbyte("sticky", 8'hff);
        check_eq("sticky", found_pattern, 1'b1);

        // Acknowledge, then history must have been cleared
        cyc("ack", 1'b0, 1'b0, P0);
        check_eq("ack_clear", found_pattern, 1'b0);
        ackbyte("nohist", P1); ackbyte("nohist", P2);
        check_eq("nohist", found_pattern, 1'b0);
        ackbyte("rehit", P0); ackbyte("rehit", P1); ackbyte("rehit", P2);
        check_eq("rehit", found_pattern, 1'b1);
        cyc("ack", 1'b0, 1'b0, 8'h00);
        cyc("ack2", 1'b0, 1'b0, P2);

        // Overlapping prefixes
        ackbyte("ovl1", P0); ackbyte("ovl1", P0); ackbyte("ovl1", P1); ackbyte("ovl1", P2);
        check_eq("ovl1", found_pattern, 1'b1);
        cyc("ack", 1'b0, 1'b0, 8'h00);
        ackbyte("ovl2", P0); ackbyte("ovl2", P1); ackbyte("ovl2", P0); ackbyte("ovl2", P1);
        check_eq("ovl2_pre", found_pattern, 1'b0);
        ackbyte("ovl2", P2);
        check_eq("ovl2", found_pattern, 1'b1);
        cyc("ack", 1'b0, 1'b0, 8'h00);
        ackbyte("gap", P0); ackbyte("gap", P1); ackbyte("gap", 8'h99); ackbyte("gap", P2);
        check_eq("gap_nohit", found_pattern, 1'b0);

        // Stall with the closing byte on data
        ackbyte("stall", P0);
        for (int i = 0; i < 3; i++) cyc("stall", 1'b0, 1'b0, P2);
        ackbyte("stall", P1); ackbyte("stall", P2);
        check_eq("stall_hit", found_pattern, 1'b1);

        // Reset while FOUND with ack high, then mid-pattern reset
        cyc("rstfound", 1'b1, 1'b1, 8'h00);
        check_eq("rst_found", found_pattern, 1'b0);
        ackbyte("rstmid", P0); ackbyte("rstmid", P1);
        cyc("rstmid", 1'b1, 1'b1, P2);
        ackbyte("rstmid", P2);
        check_eq("rst_mid", found_pattern, 1'b0);

        // Data ignored in FOUND
        ackbyte("ign", P0); ackbyte("ign", P1); ackbyte("ign", P2);
        ackbyte("ign", P0); ackbyte("ign", P1); ackbyte("ign", P2);
        check_eq("ign_hold", found_pattern, 1'b1);
        cyc("ack", 1'b0, 1'b0, 8'h00);
        ackbyte("ign_after", 8'h77);
        check_eq("ign_after", found_pattern, 1'b0);

        // Random stream over a small alphabet so hits are frequent
        for (int i = 0; i < 300; i++) begin
            logic [7:0] d;
            logic       a;
            logic       r;
            case ($urandom_range(0, 3))
                0: d = P0;
                1: d = P1;
                2: d = P2;
                default: d = 8'h99;
            endcase
            a = ($urandom_range(0, 4) != 0);
            r = ($urandom_range(0, 60) == 0);
            cyc("rand", r, a, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_detector3.md
Name: pattern_detector3

Overview:
- Byte-stream detector: samples one 8-bit byte per clock while `ack` is high and flags when the last three sampled bytes equal a programmable 3-byte pattern.
- The flag `found_pattern` is sticky. It holds until the upstream consumer acknowledges by driving `ack` low for at least one clock.
- Sits between a byte source/consumer that stalls while the flag is up, and any logic that reacts to pattern hits.

Parameters:
- BYTE0, default 8'h12: first (oldest) pattern byte.
- BYTE1, default 8'h34: second pattern byte.
- BYTE2, default 8'h56: third (newest) pattern byte.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset_sync`  input  1  synchronous, active-high reset; sampled on rising `clk`.
- `data`  input  8  stream byte; sampled only when accepted (see Behaviour).
- `ack`  input  1  high = byte on `data` is valid/present; low while `found_pattern`=1 = acknowledge; low in SEARCH = stall.
- `found_pattern`  output  1  registered pattern-hit flag, sticky until acknowledged.

Behaviour:
- State: two history byte registers h1 (older) and h0 (newer), a 2-bit fill count cnt (0..2, saturating), and a 1-bit state SEARCH/FOUND.
- `found_pattern` = (state==FOUND), driven directly from the register.
- Reset: `reset_sync`=1 at a rising edge sets state=SEARCH, cnt=0, h1=h0=8'h00, `found_pattern`=0. Reset has priority over all other conditions, including mid-FOUND and mid-pattern; partial matches are discarded.
- Accept: a byte is accepted at a rising edge iff `reset_sync`=0, state==SEARCH and `ack`=1.
- SEARCH, `ack`=0: hold all state (stall); `data` ignored.
- SEARCH, accepted byte d, match condition: cnt==2 and h1==BYTE0 and h0==BYTE1 and d==BYTE2.
  - On match: state goes to FOUND at that edge. `found_pattern` is 1 in the cycle after the edge that sampled BYTE2 (one-cycle latency). History is cleared (cnt=0).
  - No match: shift in (h1<=h0, h0<=d), cnt<=min(cnt+1,2).
- Overlap: detection is a sliding window over accepted bytes, so a repeated prefix does not lose alignment. Example: 12 12 34 56 is a hit.
- After a hit, history restarts empty. Bytes of one hit are never reused for the next hit (non-overlapping between hits).
- FOUND, `ack`=1: hold FOUND; `data` ignored (no shift, no count change).
- FOUND, `ack`=0 at a rising edge: state<=SEARCH, cnt=0, h1=h0=8'h00. `found_pattern` is 0 from the next cycle. The byte present during that edge is not sampled.
- First byte eligible for a new search is the one present at the first rising edge after the acknowledge edge with `ack`=1.
- `ack` held low for several cycles in FOUND: the first low edge clears; remaining low cycles are SEARCH stalls.
- Pattern bytes may be equal to each other (e.g. 00 00 00). The sliding-window rule still applies.
- No combinational path from inputs to `found_pattern`.

Test Plan:
- Reset then stream 12,34,56 with `ack`=1 → `found_pattern`=0 for the first two accepted cycles, =1 exactly one cycle after 56 is sampled, and stays 1 while `ack`=1.
- Hit acknowledged: with `found_pattern`=1, drop `ack` for one edge → `found_pattern`=0 next cycle. Then stream 34,56 → no hit, because history was cleared. Then stream 12,34,56 → hit.
- Overlap/prefix: stream 12,12,34,56 → hit after 56. Stream 12,34,12,34,56 → single hit after 56. Stream 12,34,99,56 → no hit.
- Stall: stream 12, then `ack`=0 for 3 cycles while `data`=56, then 34,56 with `ack`=1 → hit (stalled bytes ignored).
- Reset mid-operation: after 12,34 accepted, assert `reset_sync`=1 for one edge, then 56 → no hit. Reset asserted while `found_pattern`=1 → `found_pattern`=0 next cycle regardless of `ack`.
- Data ignored in FOUND: while `found_pattern`=1 and `ack`=1, present 12,34,56 → no second hit after the acknowledge; `found_pattern` stays 1 until `ack` goes low.
